// File: rtl/bullet_slot_scheduler.sv
// Bullet slot scheduler: synchronizes the fire button, enforces a per-frame launch
// cooldown, allocates the lowest free bullet slot and retires slots on done.
module bullet_slot_scheduler #(
  parameter int NSLOT           = 5,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int CD_W            = 4,
  parameter int CNT_W           = 8
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic             i_pause,
  input  logic             i_enable,
  input  logic             i_fire_btn,
  input  logic             i_frame_tick,
  input  logic [NSLOT-1:0] i_b_done,
  output logic [NSLOT-1:0] o_b_active,
  output logic [NSLOT-1:0] o_b_launch,
  output logic             o_fire_drop,
  output logic             o_cooldown_busy,
  output logic [CNT_W-1:0] o_shot_count
);

  localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(COOLDOWN_FRAMES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_fire_edge;
  logic             r_pending;
  logic [CD_W-1:0]  r_cd;
  logic [NSLOT-1:0] r_active;
  logic [NSLOT-1:0] r_launch;
  logic             r_drop;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fire_edge;
  logic [NSLOT-1:0] w_sel;
  logic [NSLOT-1:0] w_active_nxt;
  logic [NSLOT-1:0] w_launch_nxt;
  logic             w_drop_nxt;
  logic             w_pending_nxt;
  logic [CD_W-1:0]  w_cd_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // One-hot of the lowest-index clear bit of the mask; zero when the mask is full.
  function automatic logic [NSLOT-1:0] lowest_free(input logic [NSLOT-1:0] act);
    logic [NSLOT-1:0] sel;
    sel = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!act[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_fire_edge = r_sync2 & ~r_prev;
  assign w_sel       = lowest_free(r_active);

  // Next-state decode: enable-off clears, pause only retires, otherwise allocate.
  always_comb begin
    w_active_nxt  = r_active & ~i_b_done;
    w_launch_nxt  = '0;
    w_drop_nxt    = 1'b0;
    w_pending_nxt = r_pending;
    w_cd_nxt      = r_cd;
    w_cnt_nxt     = r_cnt;
    if (!i_enable) begin
      w_active_nxt  = '0;
      w_pending_nxt = 1'b0;
      w_cd_nxt      = '0;
    end else if (i_pause) begin
      w_active_nxt  = r_active & ~i_b_done;
      w_pending_nxt = r_pending;
    end else if (i_frame_tick && r_pending && (r_cd == '0)) begin
      w_pending_nxt = 1'b0;
      if (w_sel != '0) begin
        // Allocator works from the pre-retire mask, so a retiring slot is never reused here.
        w_launch_nxt = w_sel;
        w_active_nxt = (r_active & ~i_b_done) | w_sel;
        w_cd_nxt     = CD_RELOAD;
        if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end else begin
        w_drop_nxt = 1'b1;
      end
    end else begin
      if (r_pending) begin
        w_pending_nxt = 1'b1;
      end else begin
        w_pending_nxt = r_fire_edge;
      end
      if (i_frame_tick && (r_cd != '0)) begin
        w_cd_nxt = r_cd - CD_W'(1);
      end else begin
        w_cd_nxt = r_cd;
      end
    end
  end

  // Fire button synchronizer and registered edge detect.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_prev      <= 1'b0;
      r_fire_edge <= 1'b0;
    end else begin
      r_sync1     <= i_fire_btn;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_fire_edge <= w_fire_edge;
    end
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      r_active  <= '0;
      r_launch  <= '0;
      r_drop    <= 1'b0;
      r_pending <= 1'b0;
      r_cd      <= '0;
      r_cnt     <= '0;
    end else begin
      r_active  <= w_active_nxt;
      r_launch  <= w_launch_nxt;
      r_drop    <= w_drop_nxt;
      r_pending <= w_pending_nxt;
      r_cd      <= w_cd_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign o_b_active      = r_active;
  assign o_b_launch      = r_launch;
  assign o_fire_drop     = r_drop;
  assign o_cooldown_busy = (r_cd != '0);
  assign o_shot_count    = r_cnt;

endmodule

// File: tb/tb_bullet_slot_scheduler.sv
// Directed bench for bullet_slot_scheduler with hand-computed expectations.
module tb_bullet_slot_scheduler;

  logic       dclk = 1'b0;
  logic       rst;
  logic       i_pause;
  logic       i_enable;
  logic       i_fire_btn;
  logic       i_frame_tick;
  logic [4:0] i_b_done;
  logic [4:0] o_b_active;
  logic [4:0] o_b_launch;
  logic       o_fire_drop;
  logic       o_cooldown_busy;
  logic [7:0] o_shot_count;

  int n_checks = 0;
  int n_errors = 0;

  bullet_slot_scheduler #(
    .NSLOT(5), .COOLDOWN_FRAMES(4), .CD_W(4), .CNT_W(8)
  ) dut (
    .dclk(dclk), .rst(rst), .i_pause(i_pause), .i_enable(i_enable),
    .i_fire_btn(i_fire_btn), .i_frame_tick(i_frame_tick), .i_b_done(i_b_done),
    .o_b_active(o_b_active), .o_b_launch(o_b_launch), .o_fire_drop(o_fire_drop),
    .o_cooldown_busy(o_cooldown_busy), .o_shot_count(o_shot_count)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge dclk);
    #1;
  endtask

  task automatic tick();
    i_frame_tick = 1'b1;
    cyc();
    i_frame_tick = 1'b0;
  endtask

  // Press and release long enough for the edge to reach the pending flag.
  task automatic press();
    i_fire_btn = 1'b1;
    repeat (5) cyc();
    i_fire_btn = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic clear_cd();
    for (int i = 0; i < 4; i++) tick();
  endtask

  logic [4:0] acc;

  initial begin
    rst = 1'b1; i_pause = 1'b0; i_enable = 1'b0; i_fire_btn = 1'b0;
    i_frame_tick = 1'b0; i_b_done = 5'b00000;
    repeat (2) cyc();
    chk("rst_active", {27'd0, o_b_active}, 32'h0);
    chk("rst_launch", {27'd0, o_b_launch}, 32'h0);
    chk("rst_drop", {31'd0, o_fire_drop}, 32'h0);
    chk("rst_busy", {31'd0, o_cooldown_busy}, 32'h0);
    chk("rst_cnt", {24'd0, o_shot_count}, 32'h0);
    rst = 1'b0;
    i_enable = 1'b1;
    cyc();

    // first launch
    press();
    tick();
    chk("l1_launch", {27'd0, o_b_launch}, 32'h01);
    chk("l1_active", {27'd0, o_b_active}, 32'h01);
    chk("l1_cnt", {24'd0, o_shot_count}, 32'd1);
    chk("l1_busy", {31'd0, o_cooldown_busy}, 32'h1);
    cyc();
    chk("l1_pulse", {27'd0, o_b_launch}, 32'h0);

    // cooldown holds a pending shot for four ticks
    press();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cd_hold", {27'd0, o_b_launch}, 32'h0);
    end
    chk("cd_zero", {31'd0, o_cooldown_busy}, 32'h0);
    tick();
    chk("l2_launch", {27'd0, o_b_launch}, 32'h02);
    chk("l2_active", {27'd0, o_b_active}, 32'h03);
    chk("l2_cnt", {24'd0, o_shot_count}, 32'd2);

    // pause with cooldown at 3
    tick();
    i_pause = 1'b1;
    tick(); tick();
    press();
    chk("pz_active", {27'd0, o_b_active}, 32'h03);
    chk("pz_busy", {31'd0, o_cooldown_busy}, 32'h1);
    chk("pz_cnt", {24'd0, o_shot_count}, 32'd2);
    chk("pz_launch", {27'd0, o_b_launch}, 32'h0);
    i_b_done = 5'b00001;
    cyc();
    i_b_done = 5'b00000;
    chk("pz_retire", {27'd0, o_b_active}, 32'h02);
    i_pause = 1'b0;
    cyc();
    tick(); tick();
    chk("pz_resume2", {31'd0, o_cooldown_busy}, 32'h1);
    acc = o_b_launch;
    tick();
    acc = acc | o_b_launch;
    chk("pz_resume3", {31'd0, o_cooldown_busy}, 32'h0);
    chk("pz_no_latch", {27'd0, acc}, 32'h0);

    // build 00111
    press(); tick();
    chk("l3_launch", {27'd0, o_b_launch}, 32'h01);
    clear_cd();
    press(); tick();
    chk("l4_active", {27'd0, o_b_active}, 32'h07);
    chk("l4_cnt", {24'd0, o_shot_count}, 32'd4);
    clear_cd();

    // retire slot 1 while allocating
    press();
    i_b_done = 5'b00010;
    tick();
    i_b_done = 5'b00000;
    chk("rr_launch", {27'd0, o_b_launch}, 32'h08);
    chk("rr_active", {27'd0, o_b_active}, 32'h0D);
    chk("rr_cnt", {24'd0, o_shot_count}, 32'd5);
    clear_cd();

    // fill remaining slots then drop
    press(); tick();
    chk("f1_launch", {27'd0, o_b_launch}, 32'h02);
    clear_cd();
    press(); tick();
    chk("f2_active", {27'd0, o_b_active}, 32'h1F);
    clear_cd();
    press(); tick();
    chk("dr_drop", {31'd0, o_fire_drop}, 32'h1);
    chk("dr_launch", {27'd0, o_b_launch}, 32'h0);
    chk("dr_active", {27'd0, o_b_active}, 32'h1F);
    chk("dr_cnt", {24'd0, o_shot_count}, 32'd7);
    cyc();
    chk("dr_pulse", {31'd0, o_fire_drop}, 32'h0);

    // enable drop with pending shot
    i_b_done = 5'b01010;
    cyc();
    i_b_done = 5'b00000;
    chk("en_pre", {27'd0, o_b_active}, 32'h15);
    press();
    i_enable = 1'b0;
    cyc();
    chk("en_active", {27'd0, o_b_active}, 32'h0);
    chk("en_cnt", {24'd0, o_shot_count}, 32'd7);
    i_enable = 1'b1;
    tick();
    chk("en_nolaunch", {27'd0, o_b_launch}, 32'h0);

    // reset mid-flight
    press(); tick();
    chk("rm_launch", {27'd0, o_b_launch}, 32'h01);
    chk("rm_cnt", {24'd0, o_shot_count}, 32'd8);
    press();
    #2 rst = 1'b1;
    #1;
    chk("rm_active", {27'd0, o_b_active}, 32'h0);
    chk("rm_cntclr", {24'd0, o_shot_count}, 32'd0);
    @(negedge dclk);
    rst = 1'b0;
    acc = 5'b00000;
    for (int i = 0; i < 6; i++) begin
      tick();
      acc = acc | o_b_launch;
    end
    chk("rm_nolaunch", {27'd0, acc}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
